// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one single-port memory between the
// fetch unit and the execution unit, with one transaction in flight at a time.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 12,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ifu_rd_req,
  input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
  output logic [DATA_WIDTH-1:0] ifu_rd_data,
  output logic                  ifu_rd_ack,
  input  logic                  exu_rd_req,
  input  logic [ADDR_WIDTH-1:0] exu_rd_addr,
  output logic [DATA_WIDTH-1:0] exu_rd_data,
  output logic                  exu_rd_ack,
  input  logic                  exu_wr_req,
  input  logic [ADDR_WIDTH-1:0] exu_wr_addr,
  input  logic [DATA_WIDTH-1:0] exu_wr_data,
  output logic                  exu_wr_ack,
  output logic                  mem_rd_req,
  output logic                  mem_wr_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  arb_err
);

  // state | meaning
  // IDLE  | sample requests, pick winner, register address and write data
  // ISSUE | single-cycle memory strobe
  // WAIT  | count down read latency, capture read data at terminal count
  // DONE  | single-cycle ack to the winner, requests ignored
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [2:0] LAT_LOAD = 3'(RD_LAT);

  state_t     state, state_nxt;
  logic       last_exu;
  logic       win_exu;
  logic       op_wr;
  logic [2:0] lat_cnt;

  logic exu_req, grant, grant_exu, grant_wr, lat_done;

  // EXU wins when alone, or on contention when IFU held the last grant;
  // a simultaneous EXU read/write resolves to the write.
  always_comb begin
    exu_req   = exu_rd_req | exu_wr_req;
    grant     = (state == IDLE) && (ifu_rd_req || exu_req);
    grant_exu = exu_req && (!ifu_rd_req || !last_exu);
    grant_wr  = grant_exu && exu_wr_req;
    lat_done  = (lat_cnt == 3'd1);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    mem_rd_req = 1'b0;
    mem_wr_req = 1'b0;
    ifu_rd_ack = 1'b0;
    exu_rd_ack = 1'b0;
    exu_wr_ack = 1'b0;
    case (state)
      IDLE: begin
        if (ifu_rd_req || exu_req) state_nxt = ISSUE;
      end
      ISSUE: begin
        mem_rd_req = !op_wr;
        mem_wr_req = op_wr;
        state_nxt  = op_wr ? DONE : WAIT;
      end
      WAIT: begin
        if (lat_done) state_nxt = DONE;
      end
      DONE: begin
        ifu_rd_ack = !win_exu;
        exu_rd_ack = win_exu && !op_wr;
        exu_wr_ack = win_exu && op_wr;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_exu    <= 1'b0;
      win_exu     <= 1'b0;
      op_wr       <= 1'b0;
      lat_cnt     <= 3'd0;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      ifu_rd_data <= '0;
      exu_rd_data <= '0;
      arb_err     <= 1'b0;
    end else begin
      if (grant) begin
        last_exu <= grant_exu;
        win_exu  <= grant_exu;
        op_wr    <= grant_wr;
        if (grant_wr)       mem_addr <= exu_wr_addr;
        else if (grant_exu) mem_addr <= exu_rd_addr;
        else                mem_addr <= ifu_rd_addr;
        if (grant_wr) mem_wr_data <= exu_wr_data;
      end
      if (state == IDLE && exu_rd_req && exu_wr_req) arb_err <= 1'b1;
      if (state == ISSUE) begin
        lat_cnt <= LAT_LOAD;
      end else if (state == WAIT) begin
        lat_cnt <= lat_cnt - 3'd1;
        if (lat_done) begin
          if (win_exu) exu_rd_data <= mem_rd_data;
          else         ifu_rd_data <= mem_rd_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at RD_LAT=1, one at RD_LAT=4,
// each backed by a pipelined memory model that shows junk outside its data slot.
module tb_mem_arbiter;
  localparam int AW = 12;
  localparam int DW = 12;
  localparam logic [DW-1:0] JUNK = 12'o6666;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          ifu_rd_req, exu_rd_req, exu_wr_req;
  logic [AW-1:0] ifu_rd_addr, exu_rd_addr, exu_wr_addr;
  logic [DW-1:0] exu_wr_data;

  logic [DW-1:0] a_ifu_rd_data, a_exu_rd_data, a_mem_wr_data, a_mem_rd_data;
  logic [AW-1:0] a_mem_addr;
  logic          a_ifu_rd_ack, a_exu_rd_ack, a_exu_wr_ack, a_mem_rd_req, a_mem_wr_req, a_arb_err;

  logic [DW-1:0] b_ifu_rd_data, b_exu_rd_data, b_mem_wr_data, b_mem_rd_data;
  logic [AW-1:0] b_mem_addr;
  logic          b_ifu_rd_ack, b_exu_rd_ack, b_exu_wr_ack, b_mem_rd_req, b_mem_wr_req, b_arb_err;
  logic [DW-1:0] b_pipe [4];

  int n_chk = 0;
  int n_bad = 0;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .ifu_rd_req(ifu_rd_req), .ifu_rd_addr(ifu_rd_addr),
    .ifu_rd_data(a_ifu_rd_data), .ifu_rd_ack(a_ifu_rd_ack),
    .exu_rd_req(exu_rd_req), .exu_rd_addr(exu_rd_addr),
    .exu_rd_data(a_exu_rd_data), .exu_rd_ack(a_exu_rd_ack),
    .exu_wr_req(exu_wr_req), .exu_wr_addr(exu_wr_addr), .exu_wr_data(exu_wr_data),
    .exu_wr_ack(a_exu_wr_ack),
    .mem_rd_req(a_mem_rd_req), .mem_wr_req(a_mem_wr_req),
    .mem_addr(a_mem_addr), .mem_wr_data(a_mem_wr_data),
    .mem_rd_data(a_mem_rd_data), .arb_err(a_arb_err)
  );

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(4)) dut4 (
    .clk(clk), .reset(reset),
    .ifu_rd_req(ifu_rd_req), .ifu_rd_addr(ifu_rd_addr),
    .ifu_rd_data(b_ifu_rd_data), .ifu_rd_ack(b_ifu_rd_ack),
    .exu_rd_req(exu_rd_req), .exu_rd_addr(exu_rd_addr),
    .exu_rd_data(b_exu_rd_data), .exu_rd_ack(b_exu_rd_ack),
    .exu_wr_req(exu_wr_req), .exu_wr_addr(exu_wr_addr), .exu_wr_data(exu_wr_data),
    .exu_wr_ack(b_exu_wr_ack),
    .mem_rd_req(b_mem_rd_req), .mem_wr_req(b_mem_wr_req),
    .mem_addr(b_mem_addr), .mem_wr_data(b_mem_wr_data),
    .mem_rd_data(b_mem_rd_data), .arb_err(b_arb_err)
  );

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    if (a == 12'o0200) return 12'o7402;
    return a ^ 12'o5252;
  endfunction

  always @(posedge clk) begin
    a_mem_rd_data <= a_mem_rd_req ? mem_val(a_mem_addr) : JUNK;
    b_pipe[0]     <= b_mem_rd_req ? mem_val(b_mem_addr) : JUNK;
    b_pipe[1]     <= b_pipe[0];
    b_pipe[2]     <= b_pipe[1];
    b_pipe[3]     <= b_pipe[2];
  end
  assign b_mem_rd_data = b_pipe[3];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0o exp=%0o", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    ifu_rd_req = 1'b0;
    exu_rd_req = 1'b0;
    exu_wr_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ifu_rd_addr = '0; exu_rd_addr = '0; exu_wr_addr = '0; exu_wr_data = '0;
    do_reset();
    chk("rst_ifu_ack", a_ifu_rd_ack, 0);
    chk("rst_rd_req", a_mem_rd_req, 0);
    chk("rst_wr_req", a_mem_wr_req, 0);
    chk("rst_addr", a_mem_addr, 0);
    chk("rst_wdata", a_mem_wr_data, 0);
    chk("rst_ifu_data", a_ifu_rd_data, 0);
    chk("rst_err", a_arb_err, 0);

    // IFU read of 0o200
    ifu_rd_req = 1'b1; ifu_rd_addr = 12'o0200;
    @(negedge clk);
    chk("t1_rd_strobe", a_mem_rd_req, 1);
    chk("t1_wr_strobe", a_mem_wr_req, 0);
    chk("t1_addr", a_mem_addr, 12'o0200);
    @(negedge clk);
    chk("t1_no_early_ack", a_ifu_rd_ack, 0);
    chk("t1_strobe_once", a_mem_rd_req, 0);
    @(negedge clk);
    chk("t1_ack", a_ifu_rd_ack, 1);
    chk("t1_data", a_ifu_rd_data, 12'o7402);
    chk("t1_no_exu_rd_ack", a_exu_rd_ack, 0);
    chk("t1_no_exu_wr_ack", a_exu_wr_ack, 0);
    ifu_rd_req = 1'b0;
    @(negedge clk);
    chk("t1_ack_pulse", a_ifu_rd_ack, 0);

    // EXU write
    exu_wr_req = 1'b1; exu_wr_addr = 12'o0050; exu_wr_data = 12'o1234;
    @(negedge clk);
    chk("t2_wr_strobe", a_mem_wr_req, 1);
    chk("t2_rd_strobe", a_mem_rd_req, 0);
    chk("t2_addr", a_mem_addr, 12'o0050);
    chk("t2_wdata", a_mem_wr_data, 12'o1234);
    chk("t2_no_early_ack", a_exu_wr_ack, 0);
    @(negedge clk);
    chk("t2_ack", a_exu_wr_ack, 1);
    chk("t2_wr_strobe_once", a_mem_wr_req, 0);
    chk("t2_addr_stable", a_mem_addr, 12'o0050);
    chk("t2_ifu_data_held", a_ifu_rd_data, 12'o7402);
    exu_wr_req = 1'b0;
    @(negedge clk);
    chk("t2_ack_pulse", a_exu_wr_ack, 0);

    // round robin under continuous contention
    do_reset();
    ifu_rd_req = 1'b1; ifu_rd_addr = 12'o1000;
    exu_rd_req = 1'b1; exu_rd_addr = 12'o2000;
    for (int g = 0; g < 6; g++) begin
      int cyc;
      bit got;
      cyc = 0; got = 1'b0;
      while (!got && cyc < 12) begin
        @(negedge clk);
        cyc++;
        chk("t3_excl", a_mem_rd_req & a_mem_wr_req, 0);
        if (a_ifu_rd_ack | a_exu_rd_ack) got = 1'b1;
      end
      chk("t3_got_ack", got, 1);
      chk("t3_spacing", cyc, (g == 0) ? 3 : 4);
      chk("t3_exu_wins", a_exu_rd_ack, (g % 2) == 0);
      chk("t3_ifu_wins", a_ifu_rd_ack, (g % 2) == 1);
      if (a_exu_rd_ack) begin
        chk("t3_exu_data", a_exu_rd_data, mem_val(exu_rd_addr));
        exu_rd_addr = exu_rd_addr + 12'o11;
      end
      if (a_ifu_rd_ack) begin
        chk("t3_ifu_data", a_ifu_rd_data, mem_val(ifu_rd_addr));
        ifu_rd_addr = ifu_rd_addr + 12'o7;
      end
    end
    ifu_rd_req = 1'b0; exu_rd_req = 1'b0;

    // EXU read and write together
    do_reset();
    exu_rd_req = 1'b1; exu_rd_addr = 12'o0300;
    exu_wr_req = 1'b1; exu_wr_addr = 12'o0400; exu_wr_data = 12'o4321;
    @(negedge clk);
    chk("t4_wr_first", a_mem_wr_req, 1);
    chk("t4_no_rd", a_mem_rd_req, 0);
    chk("t4_wr_addr", a_mem_addr, 12'o0400);
    chk("t4_err_set", a_arb_err, 1);
    @(negedge clk);
    chk("t4_wr_ack", a_exu_wr_ack, 1);
    chk("t4_no_rd_ack", a_exu_rd_ack, 0);
    exu_wr_req = 1'b0;
    @(negedge clk);
    chk("t4_err_held", a_arb_err, 1);
    @(negedge clk);
    chk("t4_rd_next", a_mem_rd_req, 1);
    chk("t4_rd_addr", a_mem_addr, 12'o0300);
    repeat (2) @(negedge clk);
    chk("t4_rd_ack", a_exu_rd_ack, 1);
    chk("t4_rd_data", a_exu_rd_data, mem_val(12'o0300));
    exu_rd_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("t4_err_sticky", a_arb_err, 1);

    // RD_LAT=4 on the second instance
    do_reset();
    chk("t5_err_cleared", a_arb_err, 0);
    chk("t5_err_cleared4", b_arb_err, 0);
    ifu_rd_req = 1'b1; ifu_rd_addr = 12'o0777;
    @(negedge clk);
    chk("t5_rd_strobe", b_mem_rd_req, 1);
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk);
      chk("t5_no_early_ack", b_ifu_rd_ack, 0);
      chk("t5_mem_slot", b_mem_rd_data, (c == 5) ? mem_val(12'o0777) : JUNK);
    end
    @(negedge clk);
    chk("t5_ack", b_ifu_rd_ack, 1);
    chk("t5_data", b_ifu_rd_data, mem_val(12'o0777));
    ifu_rd_req = 1'b0;
    @(negedge clk);
    chk("t5_ack_pulse", b_ifu_rd_ack, 0);

    // reset in WAIT of an IFU read
    do_reset();
    ifu_rd_req = 1'b1; ifu_rd_addr = 12'o0123;
    @(negedge clk);
    chk("t6_issue", a_mem_rd_req, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_no_ack", a_ifu_rd_ack, 0);
    chk("t6_data_clr", a_ifu_rd_data, 0);
    chk("t6_addr_clr", a_mem_addr, 0);
    chk("t6_rd_clr", a_mem_rd_req, 0);
    reset = 1'b0; ifu_rd_addr = 12'o0321;
    @(negedge clk);
    chk("t6_no_late_ack", a_ifu_rd_ack, 0);
    chk("t6_reissue", a_mem_rd_req, 1);
    chk("t6_readdr", a_mem_addr, 12'o0321);
    repeat (2) @(negedge clk);
    chk("t6_ack", a_ifu_rd_ack, 1);
    chk("t6_data", a_ifu_rd_data, mem_val(12'o0321));
    ifu_rd_req = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-port PDP-8 main memory between the fetch unit (instruction reads) and the execution unit (operand reads and writes). Accepts level requests from both units, picks one with round-robin priority, and drives exactly one memory transaction at a time. It returns read data with a one-cycle acknowledge pulse to the winning requester. Sits between the fetch/execution units and the memory model.

## Interface
- ADDR_WIDTH, 12, memory address width (`ADDR_WIDTH)
- DATA_WIDTH, 12, memory word width (`DATA_WIDTH)
- RD_LAT, 1, memory read latency in cycles, legal 1..4
- clk  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- ifu_rd_req  in  1  fetch read request, level, held until ifu_rd_ack
- ifu_rd_addr  in  ADDR_WIDTH  fetch address, stable while ifu_rd_req high
- ifu_rd_data  out  DATA_WIDTH  fetch read data, valid when ifu_rd_ack
- ifu_rd_ack  out  1  one-cycle completion pulse for the fetch unit
- exu_rd_req  in  1  execution read request, level
- exu_rd_addr  in  ADDR_WIDTH  execution read address
- exu_rd_data  out  DATA_WIDTH  execution read data, valid when exu_rd_ack
- exu_rd_ack  out  1  one-cycle completion pulse for an execution read
- exu_wr_req  in  1  execution write request, level
- exu_wr_addr  in  ADDR_WIDTH  execution write address
- exu_wr_data  in  DATA_WIDTH  execution write data
- exu_wr_ack  out  1  one-cycle completion pulse for an execution write
- mem_rd_req  out  1  memory read strobe, one cycle per read
- mem_wr_req  out  1  memory write strobe, one cycle per write
- mem_addr  out  ADDR_WIDTH  memory address, registered
- mem_wr_data  out  DATA_WIDTH  memory write data, registered
- mem_rd_data  in  DATA_WIDTH  memory read data, valid RD_LAT cycles after the mem_rd_req cycle
- arb_err  out  1  sticky error: exu_rd_req and exu_wr_req sampled high together

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: sample requests. If none are pending, stay in IDLE. Otherwise choose a winner, register the address and write data into mem_addr/mem_wr_data, record the operation type, and go to ISSUE.
- Requesters: IFU, and EXU (exu_rd_req or exu_wr_req).
  - With only one requester pending, it wins.
  - With both pending, the winner is the requester not granted last. The last-grant pointer updates on every grant.
  - After reset the pointer reads "IFU last", so EXU wins the first contention.
- EXU rd and wr sampled high together: the write wins, the read stays pending, and arb_err is set. arb_err clears only on reset.
- ISSUE: assert mem_rd_req or mem_wr_req for exactly this one cycle. A write goes to DONE. A read loads the latency counter with RD_LAT and goes to WAIT.
- WAIT: decrement the counter each cycle. When it reaches 0, capture mem_rd_data into the winner's rd_data register and go to DONE.
- DONE: pulse the winner's ack for one cycle and go to IDLE. Requests are ignored in DONE.
- Requester contract: deassert req, or present a new request, by the edge that ends the ack cycle. A req still high in the next IDLE cycle is treated as a new request.
- ifu_rd_data/exu_rd_data hold their last value until that port's next read ack.
- Only one transaction is outstanding at any time. mem_rd_req and mem_wr_req are never high together.
- Reset in any state: go to IDLE, drop any in-flight transaction without an ack, and clear all outputs.

## Timing
- Reset values: all acks 0, mem_rd_req 0, mem_wr_req 0, mem_addr 0, mem_wr_data 0, ifu_rd_data 0, exu_rd_data 0, arb_err 0, pointer = IFU-last.
- Read, with request sampled in IDLE cycle T:
  - ISSUE in T+1.
  - Data captured at the end of T+1+RD_LAT.
  - Ack in T+2+RD_LAT.
  - Total occupancy is RD_LAT+3 cycles, counting the IDLE cycle (4 cycles at RD_LAT=1).
- Write, with request sampled in T: mem_wr_req in T+1, exu_wr_ack in T+2. Total occupancy 3 cycles.
- mem_addr and mem_wr_data are stable from ISSUE through DONE.
- The latency counter is 3 bits wide.

## Test plan
- Reset, then ifu_rd_req with address 0o200 and RD_LAT=1. Memory returns 0o7402 in the cycle after mem_rd_req. Expect mem_rd_req one cycle after the request, ifu_rd_ack one cycle after data, ifu_rd_data=0o7402, and no exu ack.
- exu_wr_req with address 0o0050 and data 0o1234. Expect a single mem_wr_req cycle with mem_addr=0o0050 and mem_wr_data=0o1234, and exu_wr_ack exactly 2 cycles after the request was sampled.
- IFU and EXU read requests held continuously for 6 grants. Expect grants EXU, IFU, EXU, IFU, EXU, IFU. Expect mem_rd_req and mem_wr_req never high together, and each ack to carry its own data.
- exu_rd_req and exu_wr_req raised in the same cycle. Expect the write serviced first, arb_err=1 and held, then the read serviced next, and arb_err still 1 until reset.
- RD_LAT=4 read. Expect ack 6 cycles after the request was sampled, and data taken from the 4th cycle after mem_rd_req, not earlier.
- Reset asserted during WAIT of an IFU read. Expect no ifu_rd_ack, all outputs at reset values the next cycle, and a subsequent request to complete normally.
